// File: rtl/timer_pkg.sv
// Shared definitions for the timer bank: mode encodings, one-shot FSM states
// and the width of the configuration channel index.
package timer_pkg;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    localparam int CFG_CH_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/timer_bank_if.sv
// Control, configuration and status bundle of the timer bank.
interface timer_bank_if
    import timer_pkg::*;
#(
    parameter int WIDTH    = 25,
    parameter int CHANNELS = 4
);

    logic [CHANNELS-1:0] enable;
    logic [CHANNELS-1:0] mode;
    logic [CHANNELS-1:0] start;
    logic                cfg_we;
    logic [CFG_CH_W-1:0] cfg_ch;
    logic [WIDTH-1:0]    cfg_period;
    logic [CHANNELS-1:0] seg;
    logic [CHANNELS-1:0] tick;
    logic [CHANNELS-1:0] busy;

    modport master (
        output enable, mode, start, cfg_we, cfg_ch, cfg_period,
        input  seg, tick, busy
    );

    modport slave (
        input  enable, mode, start, cfg_we, cfg_ch, cfg_period,
        output seg, tick, busy
    );

endinterface

// File: rtl/timer_channel.sv
// One terminal-count timer: shadow/active period, counter, one-shot FSM and
// registered q/tick/busy. seg is the active-low view of q.
module timer_channel #(
    parameter int               WIDTH          = 25,
    parameter logic [WIDTH-1:0] DEFAULT_PERIOD = 25'd24999999
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable_i,
    input  logic             mode_i,
    input  logic             start_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_period_i,
    output logic             seg_o,
    output logic             tick_o,
    output logic             busy_o
);
    import timer_pkg::*;

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] active_q;
    state_e           state_q;
    logic             mode_q;
    logic             q_q;
    logic             tick_q;
    logic             busy_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q    <= '0;
            shadow_q <= DEFAULT_PERIOD;
            active_q <= DEFAULT_PERIOD;
            state_q  <= ST_IDLE;
            // Track the mode during reset so a mode held across reset is not seen as a change.
            mode_q   <= mode_i;
            q_q      <= 1'b0;
            tick_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            mode_q <= mode_i;
            tick_q <= 1'b0;
            if (wr_en_i) begin
                shadow_q <= wr_period_i;
            end

            if (mode_i != mode_q) begin
                cnt_q   <= '0;
                q_q     <= 1'b0;
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
            end else if (mode_q == MODE_PERIODIC) begin
                if (enable_i) begin
                    if (cnt_q == active_q) begin
                        cnt_q    <= '0;
                        q_q      <= ~q_q;
                        tick_q   <= 1'b1;
                        active_q <= shadow_q;
                    end else begin
                        cnt_q <= cnt_q + WIDTH'(1);
                    end
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_i && enable_i) begin
                            state_q  <= ST_RUN;
                            q_q      <= 1'b1;
                            busy_q   <= 1'b1;
                            cnt_q    <= '0;
                            active_q <= shadow_q;
                        end
                    end
                    ST_RUN: begin
                        if (enable_i) begin
                            // Retrigger wins over a coincident terminal count.
                            if (start_i) begin
                                cnt_q <= '0;
                            end else if (cnt_q == active_q) begin
                                cnt_q   <= '0;
                                q_q     <= 1'b0;
                                tick_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= ST_IDLE;
                            end else begin
                                cnt_q <= cnt_q + WIDTH'(1);
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign seg_o  = ~q_q;
    assign tick_o = tick_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/timer_bank.sv
// Bank of independent terminal-count timers: decodes period writes to a
// per-channel strobe and gathers the channel outputs.
module timer_bank
    import timer_pkg::*;
#(
    parameter int               WIDTH          = 25,
    parameter int               CHANNELS       = 4,
    parameter logic [WIDTH-1:0] DEFAULT_PERIOD = 25'd24999999
) (
    input logic         clock,
    input logic         reset,
    timer_bank_if.slave bus
);

    logic [CHANNELS-1:0] wr_en;
    logic [CHANNELS-1:0] seg_w;
    logic [CHANNELS-1:0] tick_w;
    logic [CHANNELS-1:0] busy_w;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        // Indices at or above CHANNELS match no channel and are dropped.
        assign wr_en[gi] = bus.cfg_we && (bus.cfg_ch == CFG_CH_W'(gi));

        timer_channel #(
            .WIDTH          (WIDTH),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_channel (
            .clock       (clock),
            .reset       (reset),
            .enable_i    (bus.enable[gi]),
            .mode_i      (bus.mode[gi]),
            .start_i     (bus.start[gi]),
            .wr_en_i     (wr_en[gi]),
            .wr_period_i (bus.cfg_period),
            .seg_o       (seg_w[gi]),
            .tick_o      (tick_w[gi]),
            .busy_o      (busy_w[gi])
        );
    end

    assign bus.seg  = seg_w;
    assign bus.tick = tick_w;
    assign bus.busy = busy_w;

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank with a short default period so terminal counts
// are reachable; every expected value is hand-derived from the timer behaviour.
module tb_timer_bank;

    localparam int WIDTH    = 25;
    localparam int CHANNELS = 4;

    logic clk = 1'b0;
    logic rst;
    int   vectors    = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    timer_bank_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

    timer_bank #(
        .WIDTH          (WIDTH),
        .CHANNELS       (CHANNELS),
        .DEFAULT_PERIOD (25'd3)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.enable = '0;
        bus.start = '0;
        bus.cfg_we = 1'b0;
        bus.cfg_ch = '0;
        bus.cfg_period = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic exp_t;
        bus.mode = '0;
        do_reset();
        vectors++;
        if (bus.seg !== 4'b1111) begin
            miscompares++;
            $display("FAIL reset_seg got %b want 1111", bus.seg);
        end
        vectors++;
        if (bus.tick !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_tick got %b want 0000", bus.tick);
        end
        vectors++;
        if (bus.busy !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_busy got %b want 0000", bus.busy);
        end
        bus.enable = 4'b0001;
        for (int k = 1; k <= 5; k++) begin
            step();
            exp_t = (k == 4);
            vectors++;
            if (bus.tick[0] !== exp_t) begin
                miscompares++;
                $display("FAIL reset_first_tick k=%0d got %b want %b", k, bus.tick[0], exp_t);
            end
            $display("reset_first_tick k=%0d tick0=%b", k, bus.tick[0]);
        end
    endtask

    task automatic test_periodic();
        logic exp_t, exp_s;
        bus.mode = '0;
        do_reset();
        bus.cfg_we = 1'b1;
        bus.cfg_ch = 4'd0;
        bus.cfg_period = 25'd3;
        bus.enable = 4'b0001;
        for (int k = 1; k <= 16; k++) begin
            step();
            bus.cfg_we = 1'b0;
            exp_t = (k % 4 == 0);
            exp_s = ((k / 4) % 2 == 0);
            vectors++;
            if (bus.tick[0] !== exp_t || bus.seg[0] !== exp_s) begin
                miscompares++;
                $display("FAIL periodic k=%0d got tick=%b seg=%b want tick=%b seg=%b",
                         k, bus.tick[0], bus.seg[0], exp_t, exp_s);
            end
            $display("periodic k=%0d tick0=%b seg0=%b", k, bus.tick[0], bus.seg[0]);
        end
        vectors++;
        if (bus.busy !== 4'b0000) begin
            miscompares++;
            $display("FAIL periodic_busy got %b want 0000", bus.busy);
        end
    endtask

    task automatic test_enable_pause();
        logic exp_t, exp_s;
        bus.mode = '0;
        do_reset();
        bus.enable = 4'b0001;
        step();
        step();
        bus.enable = 4'b0000;
        for (int k = 1; k <= 5; k++) begin
            step();
            vectors++;
            if (bus.tick[0] !== 1'b0 || bus.seg[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL pause_hold k=%0d got tick=%b seg=%b want tick=0 seg=1",
                         k, bus.tick[0], bus.seg[0]);
            end
            $display("pause_hold k=%0d tick0=%b seg0=%b", k, bus.tick[0], bus.seg[0]);
        end
        bus.enable = 4'b0001;
        for (int k = 1; k <= 3; k++) begin
            step();
            exp_t = (k == 2);
            exp_s = (k < 2);
            vectors++;
            if (bus.tick[0] !== exp_t || bus.seg[0] !== exp_s) begin
                miscompares++;
                $display("FAIL pause_resume k=%0d got tick=%b seg=%b want tick=%b seg=%b",
                         k, bus.tick[0], bus.seg[0], exp_t, exp_s);
            end
            $display("pause_resume k=%0d tick0=%b seg0=%b", k, bus.tick[0], bus.seg[0]);
        end
    endtask

    // low_cycles: expected seg-low length; restart: hold start for a second edge.
    task automatic run_oneshot(input int low_cycles, input bit restart);
        logic exp_t, exp_s, exp_b;
        bus.start = 4'b0010;
        for (int k = 1; k <= low_cycles + 2; k++) begin
            step();
            bus.start = (restart && k == 1) ? 4'b0010 : 4'b0000;
            exp_s = (k > low_cycles);
            exp_b = (k <= low_cycles);
            exp_t = (k == low_cycles + 1);
            vectors++;
            if (bus.seg[1] !== exp_s || bus.busy[1] !== exp_b || bus.tick[1] !== exp_t) begin
                miscompares++;
                $display("FAIL oneshot restart=%0d k=%0d got seg=%b busy=%b tick=%b want seg=%b busy=%b tick=%b",
                         restart, k, bus.seg[1], bus.busy[1], bus.tick[1], exp_s, exp_b, exp_t);
            end
            $display("oneshot restart=%0d k=%0d seg1=%b busy1=%b tick1=%b",
                     restart, k, bus.seg[1], bus.busy[1], bus.tick[1]);
        end
    endtask

    task automatic test_oneshot();
        bus.mode = '0;
        do_reset();
        bus.mode = 4'b0010;
        bus.enable = 4'b0010;
        bus.cfg_we = 1'b1;
        bus.cfg_ch = 4'd1;
        bus.cfg_period = 25'd2;
        step();
        bus.cfg_we = 1'b0;
        vectors++;
        if (bus.seg[1] !== 1'b1 || bus.busy[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL oneshot_idle got seg=%b busy=%b want seg=1 busy=0", bus.seg[1], bus.busy[1]);
        end
        run_oneshot(3, 1'b0);
        run_oneshot(4, 1'b1);
    endtask

    task automatic test_period_update();
        logic [3:0] exp_t;
        bus.mode = '0;
        do_reset();
        bus.enable = 4'b1111;
        for (int k = 1; k <= 22; k++) begin
            bus.cfg_we = 1'b0;
            if (k == 1) begin
                bus.cfg_we = 1'b1; bus.cfg_ch = 4'd2; bus.cfg_period = 25'd5;
            end else if (k == 2) begin
                bus.cfg_we = 1'b1; bus.cfg_ch = 4'd9; bus.cfg_period = 25'd0;
            end else if (k == 13) begin
                bus.cfg_we = 1'b1; bus.cfg_ch = 4'd2; bus.cfg_period = 25'd1;
            end
            step();
            exp_t = (k % 4 == 0) ? 4'b1011 : 4'b0000;
            exp_t[2] = (k == 4 || k == 10 || k == 16 || k == 18 || k == 20 || k == 22);
            vectors++;
            if (bus.tick !== exp_t) begin
                miscompares++;
                $display("FAIL period_update k=%0d got tick=%b want %b", k, bus.tick, exp_t);
            end
            $display("period_update k=%0d tick=%b", k, bus.tick);
        end
        bus.cfg_we = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_t;
        logic       exp_s1;
        bus.mode = '0;
        do_reset();
        bus.mode = 4'b0010;
        bus.cfg_we = 1'b1; bus.cfg_ch = 4'd0; bus.cfg_period = 25'd7;
        step();
        bus.cfg_ch = 4'd1; bus.cfg_period = 25'd6;
        step();
        bus.cfg_we = 1'b0;
        bus.enable = 4'b0011;
        bus.start = 4'b0010;
        for (int k = 1; k <= 4; k++) begin
            step();
            bus.start = 4'b0000;
        end
        vectors++;
        if (bus.seg !== 4'b1100 || bus.busy !== 4'b0010) begin
            miscompares++;
            $display("FAIL reset_mid_before got seg=%b busy=%b want seg=1100 busy=0010", bus.seg, bus.busy);
        end
        rst = 1'b1;
        step();
        vectors++;
        if (bus.seg !== 4'b1111 || bus.busy !== 4'b0000 || bus.tick !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_mid_after got seg=%b busy=%b tick=%b want 1111 0000 0000",
                     bus.seg, bus.busy, bus.tick);
        end
        rst = 1'b0;
        bus.start = 4'b0010;
        for (int k = 1; k <= 6; k++) begin
            step();
            bus.start = 4'b0000;
            exp_t = 4'b0000;
            exp_t[0] = (k == 4);
            exp_t[1] = (k == 5);
            exp_s1 = (k >= 5);
            vectors++;
            if (bus.tick !== exp_t || bus.seg[1] !== exp_s1) begin
                miscompares++;
                $display("FAIL reset_mid_period k=%0d got tick=%b seg1=%b want tick=%b seg1=%b",
                         k, bus.tick, bus.seg[1], exp_t, exp_s1);
            end
            $display("reset_mid_period k=%0d tick=%b seg=%b", k, bus.tick, bus.seg);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.mode = '0;
        bus.enable = '0;
        bus.start = '0;
        bus.cfg_we = 1'b0;
        bus.cfg_ch = '0;
        bus.cfg_period = '0;
        test_reset();
        test_periodic();
        test_enable_pause();
        test_oneshot();
        test_period_update();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
